// File: rtl/addsub_rr_scheduler_pkg.sv
// Shared types and constants for the round-robin
// scheduler in front of the add/sub datapath.
package addsub_rr_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int pw_of(input int r);
    return (r < 2) ? 1 : $clog2(r);
  endfunction

  localparam int R_DEF = 4;
  localparam int PW    = pw_of(R_DEF);

endpackage

// File: rtl/addsub_rr_scheduler_rr_picker.sv
// Round-robin pick: first set request at or after
// the pointer, wrapping from R-1 back to 0.
module addsub_rr_scheduler_rr_picker
  import addsub_rr_scheduler_pkg::*;
#(
  parameter int R  = 4,
  parameter int PW = 2
) (
  input  logic [R-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] sel,
  output logic          any_req
);

  logic [2*R-1:0] dbl;
  logic [R-1:0]   rot;
  logic [PW:0]    off;
  logic [PW:0]    sum;

  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[R-1:0];
    off = '0;
    for (int i = R - 1; i >= 0; i--) begin
      if (rot[i]) off = (PW+1)'(i);
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (PW+1)'(R)) sum = sum - (PW+1)'(R);
    sel     = sum[PW-1:0];
    any_req = |req;
  end

endmodule

// File: rtl/addsub_rr_scheduler.sv
// Shares one add/sub datapath among R clients:
// grant, issue, wait for done (with timeout), respond.
module addsub_rr_scheduler
  import addsub_rr_scheduler_pkg::*;
#(
  parameter int N   = 4,
  parameter int R   = 4,
  parameter int TMO = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [R-1:0] req,
  input  logic [R*N-1:0] a_in,
  input  logic [R*N-1:0] b_in,
  input  logic [R-1:0] op_in,
  output logic [R-1:0] gnt,
  output logic [R-1:0] rsp_valid,
  output logic [N-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         rsp_err,
  output logic         busy,
  output logic         dp_rst,
  output logic [N-1:0] dp_A,
  output logic [N-1:0] dp_B,
  output logic         dp_addsub,
  output logic         dp_start,
  input  logic [N-1:0] dp_sum,
  input  logic         dp_cout,
  input  logic         dp_done
);

  localparam int PTRW = pw_of(R);

  state_t state, state_d;

  logic [PTRW-1:0] ptr, ptr_d;
  logic [PTRW-1:0] owner, owner_d;
  logic [PTRW-1:0] nxt, pick_ptr, sel;
  logic            any_req;
  logic [3:0]      cnt, cnt_d;

  logic [R-1:0] gnt_d, rsp_valid_d;
  logic [N-1:0] rsp_sum_d, dp_a_d, dp_b_d;
  logic         rsp_cout_d, rsp_err_d;
  logic         dp_addsub_d, dp_start_d;

  assign nxt = (owner == PTRW'(R - 1)) ? '0
             : owner + 1'b1;

  // RESP arbitrates from owner+1 so a waiting
  // client is granted in the very next cycle.
  assign pick_ptr = (state == S_RESP) ? nxt : ptr;

  addsub_rr_scheduler_rr_picker #(
    .R  (R),
    .PW (PTRW)
  ) u_pick (
    .req     (req),
    .ptr     (pick_ptr),
    .sel     (sel),
    .any_req (any_req)
  );

  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    owner_d     = owner;
    cnt_d       = cnt;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_sum_d   = rsp_sum;
    rsp_cout_d  = rsp_cout;
    rsp_err_d   = rsp_err;
    dp_a_d      = dp_A;
    dp_b_d      = dp_B;
    dp_addsub_d = dp_addsub;
    dp_start_d  = 1'b0;
    unique case (state)
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (state == S_RESP) ptr_d = nxt;
        if (any_req) begin
          state_d     = S_ISSUE;
          owner_d     = sel;
          gnt_d[sel]  = 1'b1;
          dp_a_d      = a_in[int'(sel)*N +: N];
          dp_b_d      = b_in[int'(sel)*N +: N];
          dp_addsub_d = op_in[sel];
        end
      end
      S_ISSUE: begin
        dp_start_d = 1'b1;
        cnt_d      = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt + 4'd1;
        if (dp_done) begin
          rsp_sum_d          = dp_sum;
          rsp_cout_d         = dp_cout;
          rsp_err_d          = 1'b0;
          rsp_valid_d[owner] = 1'b1;
          state_d            = S_RESP;
        end else if (cnt_d == 4'(TMO)) begin
          rsp_sum_d          = '0;
          rsp_cout_d         = 1'b0;
          rsp_err_d          = 1'b1;
          rsp_valid_d[owner] = 1'b1;
          state_d            = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      dp_A      <= '0;
      dp_B      <= '0;
      dp_addsub <= 1'b0;
      dp_start  <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      owner     <= owner_d;
      cnt       <= cnt_d;
      gnt       <= gnt_d;
      rsp_valid <= rsp_valid_d;
      rsp_sum   <= rsp_sum_d;
      rsp_cout  <= rsp_cout_d;
      rsp_err   <= rsp_err_d;
      busy      <= (state_d != S_IDLE);
      dp_A      <= dp_a_d;
      dp_B      <= dp_b_d;
      dp_addsub <= dp_addsub_d;
      dp_start  <= dp_start_d;
    end
  end

  always_ff @(posedge clk) begin
    dp_rst <= ~rst;
  end

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// Bench for addsub_rr_scheduler: directed and random
// transactions against a transaction-level model.
module tb_addsub_rr_scheduler;
  import addsub_rr_scheduler_pkg::*;

  localparam int N   = 4;
  localparam int R   = 4;
  localparam int TMO = 7;

  logic           clk = 1'b0;
  logic           rst;
  logic [R-1:0]   req;
  logic [R*N-1:0] a_in, b_in;
  logic [R-1:0]   op_in;
  logic [R-1:0]   gnt, rsp_valid;
  logic [N-1:0]   rsp_sum;
  logic           rsp_cout, rsp_err, busy, dp_rst;
  logic [N-1:0]   dp_A, dp_B;
  logic           dp_addsub, dp_start;
  logic [N-1:0]   dp_sum  = '0;
  logic           dp_cout = 1'b0;
  logic           dp_done = 1'b0;

  always #5 clk = ~clk;

  addsub_rr_scheduler #(.N(N), .R(R), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a_in(a_in), .b_in(b_in), .op_in(op_in),
    .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .rsp_err(rsp_err), .busy(busy), .dp_rst(dp_rst),
    .dp_A(dp_A), .dp_B(dp_B), .dp_addsub(dp_addsub),
    .dp_start(dp_start), .dp_sum(dp_sum),
    .dp_cout(dp_cout), .dp_done(dp_done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: done arrives lat cycles after start.
  int   lat  = 1;
  bit   dead = 1'b0;
  logic [N-1:0] la = '0, lb = '0;
  logic lop = 1'b0;
  int   dcnt = 0;
  bit   pend = 1'b0;

  function automatic logic [N:0] dp_calc(
    input logic [N-1:0] a, input logic [N-1:0] b,
    input logic op);
    return {1'b0, a} + {1'b0, op ? ~b : b}
         + (N+1)'(op);
  endfunction

  always @(posedge clk) begin
    dp_done <= 1'b0;
    if (dp_rst) begin
      pend <= 1'b0;
    end else if (dp_start) begin
      la   <= dp_A;
      lb   <= dp_B;
      lop  <= dp_addsub;
      dcnt <= 1;
      pend <= 1'b1;
      if (lat == 1 && !dead) begin
        dp_done <= 1'b1;
        {dp_cout, dp_sum} <= dp_calc(dp_A, dp_B, dp_addsub);
        pend <= 1'b0;
      end
    end else if (pend) begin
      dcnt <= dcnt + 1;
      if (dcnt + 1 == lat && !dead) begin
        dp_done <= 1'b1;
        {dp_cout, dp_sum} <= dp_calc(la, lb, lop);
        pend <= 1'b0;
      end
    end
  end

  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] want);
    total++;
    assert (obs === want) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, want);
    end
  endtask

  // Reference model
  int ptr_m    = 0;
  int last_gnt = 0;
  logic [N-1:0] av[R], bv[R];
  logic ov[R];

  function automatic int rr_pick(
    input logic [R-1:0] r, input int p);
    for (int k = 0; k < R; k++)
      if (r[(p + k) % R]) return (p + k) % R;
    return -1;
  endfunction

  function automatic int exp_sum(
    input int a, input int b, input int op);
    if (op == int'(OP_ADD)) return (a + b) % (1 << N);
    return (a - b + (1 << N)) % (1 << N);
  endfunction

  function automatic int exp_cout(
    input int a, input int b, input int op);
    if (op == int'(OP_ADD))
      return int'((a + b) >= (1 << N));
    return int'(a >= b);
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < R; i++) begin
      a_in[i*N +: N] = av[i];
      b_in[i*N +: N] = bv[i];
      op_in[i]       = ov[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < R; i++) begin
      av[i] = N'($urandom);
      bv[i] = N'($urandom);
      ov[i] = 1'($urandom);
    end
    drive_ops();
  endtask

  // mode: 0 drop all req after gnt,
  // 1 drop only the served bit, 2 keep all.
  task automatic serve(input logic [R-1:0] reqv,
                       input int mode,
                       input int gap);
    int s, t0, ts, got, dly;
    int ea, eb, eo;
    bit tmo;
    s   = rr_pick(reqv, ptr_m);
    req = reqv;
    got = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (gnt != '0) begin
        got = 1;
        break;
      end
    end
    chk("gnt_seen", got, 1);
    if (got == 0) begin
      req = '0;
      return;
    end
    t0 = cyc;
    chk("gnt", gnt, 32'(1) << s);
    chk("busy_gnt", busy, 1);
    if (gap > 0) chk("gnt_gap", t0 - last_gnt, gap);
    last_gnt = t0;
    ea = int'(av[s]);
    eb = int'(bv[s]);
    eo = int'(ov[s]);
    if (mode == 0) req = '0;
    else if (mode == 1) req = reqv & ~(R'(1) << s);
    av[s] = N'($urandom);
    bv[s] = N'($urandom);
    ov[s] = 1'($urandom);
    drive_ops();
    @(posedge clk); #1;
    chk("dp_start", dp_start, 1);
    chk("gnt_pulse", gnt, 0);
    chk("dp_A", dp_A, ea);
    chk("dp_B", dp_B, eb);
    chk("dp_addsub", dp_addsub, eo);
    tmo = dead || (lat >= TMO);
    dly = tmo ? TMO : lat + 1;
    ts  = cyc;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (rsp_valid != '0) begin
        got = 1;
        break;
      end
    end
    chk("rsp_seen", got, 1);
    if (got == 0) return;
    chk("rsp_delay", cyc - ts, dly);
    chk("rsp_valid", rsp_valid, 32'(1) << s);
    chk("rsp_err", rsp_err, int'(tmo));
    chk("rsp_sum", rsp_sum,
        tmo ? 0 : exp_sum(ea, eb, eo));
    chk("rsp_cout", rsp_cout,
        tmo ? 0 : exp_cout(ea, eb, eo));
    ptr_m = (s + 1) % R;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    int n;
    int mode;
    rst = 1'b0;
    req = '0;
    rand_ops();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_rsp_cout", rsp_cout, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dp_start", dp_start, 0);
    chk("rst_dp_A", dp_A, 0);
    chk("rst_dp_B", dp_B, 0);
    chk("rst_dp_addsub", dp_addsub, 0);
    chk("rst_dp_rst", dp_rst, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("dp_rst_release", dp_rst, 0);

    // Single add on requester 1: 5 + 3
    av[1] = 4'd5; bv[1] = 4'd3; ov[1] = OP_ADD;
    drive_ops();
    serve(4'b0010, 0, 0);
    @(posedge clk); #1;
    chk("rsp_pulse", rsp_valid, 0);
    chk("rsp_hold", rsp_sum, 8);
    chk("idle_busy", busy, 0);

    // Subtracts on requester 0 (pointer wraps)
    av[0] = 4'd3; bv[0] = 4'd5; ov[0] = OP_SUB;
    drive_ops();
    serve(4'b0001, 0, 0);
    av[0] = 4'd5; bv[0] = 4'd3; ov[0] = OP_SUB;
    drive_ops();
    serve(4'b0001, 0, 0);

    // Round robin with all requests held
    serve(4'b1000, 0, 0);
    serve(4'b1111, 2, 0);
    serve(4'b1111, 2, 4);
    serve(4'b1111, 2, 4);
    serve(4'b1111, 2, 4);
    serve(4'b1111, 0, 4);

    // Timeout, then a normal op
    dead = 1'b1;
    serve(4'b0100, 0, 0);
    dead = 1'b0;
    serve(4'b0100, 0, 0);

    // Done vs timeout boundary
    lat = 6;
    serve(4'b0001, 0, 0);
    lat = 7;
    serve(4'b0010, 0, 0);
    lat = 5;
    serve(4'b1000, 0, 0);

    // Reset during WAIT aborts the op
    lat = 4;
    serve(4'b0001, 0, 0);
    req = 4'b0100;
    @(posedge clk); #1;
    chk("abort_gnt", gnt, 4);
    @(posedge clk); #1;
    chk("abort_start", dp_start, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_dp_start", dp_start, 0);
    chk("abort_dp_A", dp_A, 0);
    chk("abort_rsp_sum", rsp_sum, 0);
    chk("abort_dp_rst", dp_rst, 1);
    rst = 1'b1;
    req = '0;
    ptr_m = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rsp_valid != '0) n++;
    end
    chk("abort_no_rsp", n, 0);
    serve(4'b0101, 0, 0);
    serve(4'b0100, 0, 0);

    // Random traffic
    for (int i = 0; i < 30; i++) begin
      rand_ops();
      lat  = $urandom_range(1, 8);
      dead = ($urandom_range(0, 7) == 0);
      mode = $urandom_range(0, 1);
      serve(R'($urandom_range(1, (1 << R) - 1)),
            mode, 0);
    end
    dead = 1'b0;
    req  = '0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/addsub_rr_scheduler.md
Name: addsub_rr_scheduler

Overview:
- Shares one single-cycle adder-subtractor datapath (start/done handshake, active-high datapath reset) among R requesters using round-robin arbitration.
- Per granted request, the block:
  - latches the requester's operands and opcode;
  - sequences the datapath start pulse;
  - waits for done, with a timeout;
  - returns the result to the owning requester as a one-cycle response.
- Sits between client blocks and the shared arithmetic unit.

Parameters:
- N, 4, operand/result width passed to the datapath.
- R, 4, number of requesters (2..8).
- TMO, 7, maximum WAIT cycles before a timeout response (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is synchronous and active-low.
- req  in  R  per-requester request level; held high with operands stable until gnt.
- a_in  in  R*N  operand A; requester i occupies bits [i*N +: N].
- b_in  in  R*N  operand B, same packing as a_in.
- op_in  in  R  per-requester opcode (0 add, 1 subtract).
- gnt  out  R  one-hot, one-cycle pulse; operands sampled in this cycle.
- rsp_valid  out  R  one-hot, one-cycle response pulse to the owner.
- rsp_sum  out  N  result, valid with rsp_valid.
- rsp_cout  out  1  carry-out, valid with rsp_valid.
- rsp_err  out  1  1 = timeout response (rsp_sum=0, rsp_cout=0).
- busy  out  1  high in any state other than IDLE.
- dp_rst  out  1  active-high datapath reset = registered ~rst.
- dp_A  out  N  latched operand A to the datapath.
- dp_B  out  N  latched operand B to the datapath.
- dp_addsub  out  1  latched opcode to the datapath.
- dp_start  out  1  datapath start strobe.
- dp_sum  in  N  datapath sum.
- dp_cout  in  1  datapath carry-out.
- dp_done  in  1  datapath done pulse.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE, rr pointer=0, timeout counter=0.
  - gnt, rsp_valid, rsp_sum, rsp_cout, rsp_err, busy, dp_start, dp_A, dp_B, dp_addsub all 0.
  - dp_rst=1 the cycle after rst is sampled low.
  - Reset mid-operation aborts the transaction: no rsp_valid is ever issued for it, and the requester must re-request.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - If req!=0, select the first set bit at or after pointer, wrapping R-1 -> 0.
  - Pulse gnt[sel] for one cycle.
  - Latch a_in/b_in/op_in slices of sel into dp_A/dp_B/dp_addsub, and store owner=sel.
  - Go to ISSUE.
  - If req=0, stay in IDLE.
- ISSUE: dp_start=1 for exactly one cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - dp_start=0; dp_A/dp_B/dp_addsub are held.
  - If dp_done=1, capture dp_sum/dp_cout into rsp_sum/rsp_cout, set rsp_err=0, go to RESP.
  - Otherwise increment the counter. When counter==TMO, set rsp_sum=0, rsp_cout=0, rsp_err=1, go to RESP.
  - If dp_done and counter==TMO occur together, done wins.
- RESP:
  - rsp_valid[owner]=1 for one cycle; rsp_* held stable in that cycle.
  - pointer = owner+1 mod R; go to IDLE.
  - rsp_sum/rsp_cout/rsp_err hold their value until the next capture.
- Timing:
  - With a single-cycle datapath: gnt at T, dp_start at T+1, dp_done at T+2, rsp_valid at T+3.
  - Best-case throughput is one operation per 4 cycles. A new gnt is possible in the cycle after RESP.
- req changes:
  - A req deasserted in the same cycle as its gnt is still served.
  - req changes during ISSUE/WAIT/RESP are ignored until IDLE.
- dp_done while not in WAIT: ignored.
- Fairness: any continuously asserted req is granted within R grants.
- No arithmetic inside this block; widths pass through unchanged.

Decomposition:
- Shared package:
  - state enum/localparams (IDLE=0, ISSUE=1, WAIT=2, RESP=3);
  - pointer width constant PW = clog2(R);
  - opcode constants OP_ADD=0, OP_SUB=1.
- One natural sub-module: rr_picker.
  - Purely combinational.
  - Inputs: req and pointer. Outputs: sel index and any_req.
  - Implemented as a double-width rotate and priority encode.

Test Plan:
- Single request: R=4, req=0010, a=5, b=3, op=0 -> gnt=0010 at T, dp_start at T+1, rsp_valid=0010 at T+3 with rsp_sum=8, rsp_cout=0, rsp_err=0.
- Subtract: req=0001, a=3, b=5, op=1 -> rsp_sum=14 (4'b1110), rsp_cout=0; then a=5, b=3 -> rsp_sum=2, rsp_cout=1.
- Round-robin: req=1111 held continuously -> grants in order 0001, 0010, 0100, 1000, 0001, each 4 cycles apart; responses go to the matching owner.
- Timeout: datapath model never raises dp_done, TMO=7 -> rsp_valid to owner with rsp_err=1, rsp_sum=0, 7 WAIT cycles after dp_start; the next request is then served normally.
- Reset mid-operation: assert rst=0 during WAIT -> next cycle state is IDLE; no rsp_valid for the aborted op; dp_rst=1; pointer=0; the re-asserted req is served afresh.
- Done/timeout collision: dp_done raised exactly when counter==TMO -> response carries dp_sum with rsp_err=0.
